sram_like_arbiter: RTL
======================

# sram_like_arbiter

Two-port arbiter sharing a single SRAM-like memory bus between the instruction-fetch port (IF stage) and the data port (EX/MEM stages). It selects one requester per cycle and holds that selection until the bus accepts the address. It records the owner of every accepted transaction in an in-order ID FIFO and routes each returning `data_ok`/`rdata` to the port that issued it. It sits between the pipeline stages and the SRAM-like-to-AXI bridge.

## Interface
- `DEPTH`, 4: maximum outstanding accepted-but-not-returned transactions (power of two, ≥2).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `inst_req` in 1: IF request valid.
- `inst_wr` in 1: IF write flag.
- `inst_size` in 2: IF access size (0 = byte, 1 = half, 2 = word).
- `inst_addr` in 32: IF address.
- `inst_wstrb` in 4: IF byte strobes.
- `inst_wdata` in 32: IF write data.
- `inst_addr_ok` out 1: IF request accepted this cycle.
- `inst_data_ok` out 1: IF response this cycle.
- `inst_rdata` out 32: IF read data.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wstrb`, `data_wdata`, `data_addr_ok`, `data_data_ok`, `data_rdata`: same meanings as the `inst_*` signals, for the data port.
- `bus_req`, `bus_wr`, `bus_size`, `bus_addr`, `bus_wstrb`, `bus_wdata` out: request to the bridge.
- `bus_addr_ok` in 1: bridge accepted the request.
- `bus_data_ok` in 1: bridge response valid.
- `bus_rdata` in 32: response data.
- `outstanding` out log2(DEPTH)+1: current ID FIFO occupancy.
- `err_orphan` out 1: sticky flag; `bus_data_ok` arrived with the FIFO empty.

## Operation
- Grant FSM with two states:
  - IDLE: choose a winner among the requesting ports. When both request, the arbitration policy decides (see Configuration). If `bus_addr_ok` is 0 in the same cycle, latch the winner and go to HOLD.
  - HOLD: grant is forced to the latched port. `bus_addr_ok` = 1 returns the FSM to IDLE. If the latched port drops its `req`, `bus_req` drops and the FSM returns to IDLE without pushing.
- `bus_*` request fields are a mux of the granted port's fields.
- `bus_req` = granted port `req` AND FIFO not full.
- `X_addr_ok` = `bus_addr_ok` AND `bus_req` AND grant == X. The non-granted port always sees `addr_ok` = 0.
- On an `addr_ok` handshake, push the owner ID (0 = inst, 1 = data) into the FIFO.
- On `bus_data_ok`, pop the FIFO head and pulse the `data_ok` of the head owner.
  - `bus_rdata` drives both `rdata` outputs unchanged.
  - Writes also return `data_ok` and are routed identically.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - A pop from a FIFO holding exactly 1 entry, with a simultaneous push, routes the pop to the old head.
- FIFO full: `bus_req` = 0. No `addr_ok` reaches either port. The FSM stays in its state.
- FIFO empty with `bus_data_ok`: no port `data_ok` fires, `err_orphan` sets, occupancy stays 0.
- Pointer arithmetic is mod DEPTH. The wrap from DEPTH−1 to 0 is seamless.

## Timing
- Arbitration, `addr_ok`, `data_ok` and `rdata` paths are combinational: zero added latency.
- State (FSM, FIFO, policy pointer, `err_orphan`) updates on `posedge clk`.
- After reset:
  - FSM is IDLE, FIFO is empty, `outstanding` = 0, `err_orphan` = 0, policy pointer = data.
  - All port `addr_ok`/`data_ok` are 0 unless the inputs drive them combinationally.
  - `bus_req` equals the granted input `req`.
- Reset mid-transaction discards all FIFO entries and the latched grant. Late `bus_data_ok` pulses then set `err_orphan`; the bridge must be reset together with the arbiter.
- Request fields must stay stable while in HOLD. This is guaranteed by the grant lock, provided the port itself keeps its fields stable.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - Defined: when both ports request in IDLE, the winner is the port opposite to the last port that completed an `addr_ok` handshake. The pointer updates only on a handshake.
  - Undefined: fixed priority, data port always wins. No pointer register is built.

## Test plan
- Reset, then IF word read at 0x1c000000 with bridge `addr_ok` on cycle 1 and `data_ok` on cycle 3 returning 0x02800000 -> `inst_addr_ok` on cycle 1, `inst_data_ok` on cycle 3 with `inst_rdata` = 0x02800000, `outstanding` 0→1→0.
- Both ports request on the same cycle, `bus_addr_ok` held 0 for 2 cycles then 1 -> with the macro undefined, data is granted and held for all 3 cycles and inst stays blocked; with the macro defined, the second contended grant goes to inst.
- Issue 4 back-to-back accepted requests (inst, data, inst, data) with `DEPTH` = 4 and no responses -> 5th request sees `bus_req` = 0 and `outstanding` = 4. Four `data_ok` pulses then route to inst, data, inst, data in order.
- Push and pop on the same cycle with `outstanding` = 1 -> old head's port gets `data_ok`, `outstanding` stays 1, and the pointers wrap correctly over 8 further such cycles.
- `bus_data_ok` pulse with the FIFO empty -> no port `data_ok`, `err_orphan` = 1 and stays set until reset.
- Reset asserted with `outstanding` = 2 -> next cycle `outstanding` = 0, FSM is IDLE, and a new request is granted normally.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Two-port (inst/data) arbiter for one SRAM-like bus with an in-order owner FIFO for responses.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is data-port priority.
module sram_like_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     inst_req,
   input  logic                     inst_wr,
   input  logic [1:0]               inst_size,
   input  logic [31:0]              inst_addr,
   input  logic [3:0]               inst_wstrb,
   input  logic [31:0]              inst_wdata,
   output logic                     inst_addr_ok,
   output logic                     inst_data_ok,
   output logic [31:0]              inst_rdata,
   input  logic                     data_req,
   input  logic                     data_wr,
   input  logic [1:0]               data_size,
   input  logic [31:0]              data_addr,
   input  logic [3:0]               data_wstrb,
   input  logic [31:0]              data_wdata,
   output logic                     data_addr_ok,
   output logic                     data_data_ok,
   output logic [31:0]              data_rdata,
   output logic                     bus_req,
   output logic                     bus_wr,
   output logic [1:0]               bus_size,
   output logic [31:0]              bus_addr,
   output logic [3:0]               bus_wstrb,
   output logic [31:0]              bus_wdata,
   input  logic                     bus_addr_ok,
   input  logic                     bus_data_ok,
   input  logic [31:0]              bus_rdata,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     err_orphan
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state_q, state_d;
   logic              hold_sel_q, hold_sel_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [DEPTH-1:0]  owner_q, owner_d;
   logic              err_q, err_d;

   logic grant_sel, winner, gnt_req, full, empty, push, pop, head;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q, last_d;
   assign winner = ~last_q;
`else
   assign winner = 1'b1;
`endif

   // Grant select: 0 = inst, 1 = data. HOLD pins the grant to the latched port.
   always_comb begin
      grant_sel = 1'b0;
      if (state_q == HOLD)
         grant_sel = hold_sel_q;
      else if (inst_req && data_req)
         grant_sel = winner;
      else
         grant_sel = data_req;
   end

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign gnt_req = grant_sel ? data_req : inst_req;
   assign bus_req = gnt_req && !full;
   assign push    = bus_req && bus_addr_ok;
   assign pop     = bus_data_ok && !empty;
   assign head    = owner_q[rd_ptr_q];

   assign bus_wr    = grant_sel ? data_wr    : inst_wr;
   assign bus_size  = grant_sel ? data_size  : inst_size;
   assign bus_addr  = grant_sel ? data_addr  : inst_addr;
   assign bus_wstrb = grant_sel ? data_wstrb : inst_wstrb;
   assign bus_wdata = grant_sel ? data_wdata : inst_wdata;

   assign inst_addr_ok = push && !grant_sel;
   assign data_addr_ok = push &&  grant_sel;
   assign inst_data_ok = pop  && !head;
   assign data_data_ok = pop  &&  head;
   assign inst_rdata   = bus_rdata;
   assign data_rdata   = bus_rdata;
   assign outstanding  = count_q;
   assign err_orphan   = err_q;

   always_comb begin
      state_d    = state_q;
      hold_sel_d = hold_sel_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      owner_d    = owner_q;
      err_d      = err_q | (bus_data_ok & empty);
`ifdef ARB_ROUND_ROBIN_EN
      last_d     = push ? grant_sel : last_q;
`endif
      case (state_q)
         IDLE: if (bus_req && !bus_addr_ok) begin
            state_d    = HOLD;
            hold_sel_d = grant_sel;
         end
         HOLD: if (!gnt_req || push) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (push) begin
         owner_d[wr_ptr_q] = grant_sel;
         wr_ptr_d          = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         hold_sel_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_q     <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         hold_sel_q <= hold_sel_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         err_q      <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_q     <= last_d;
`endif
      end
   end

   // Owner storage is plain data; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      owner_q <= owner_d;
   end

endmodule
